qr_job_sched: RTL and testbench

QR_JOB_SCHED -- requirements
Module: qr_job_sched

---
 rtl/qr_job_sched_if.sv | 37 +++
 rtl/qr_job_sched.sv | 183 ++++++++++++++++++
 tb/tb_qr_job_sched.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/qr_job_sched_if.sv
// Signal bundle between qr_job_sched and its input FIFO, QR datapath and output FIFO.
// The slave modport is the scheduler's view; the master modport is the environment's view.
interface qr_job_sched_if #(
  parameter int TBITS       = 32,
  parameter int TBYTE       = 4,
  parameter int DATA_LENGTH = 13
);
  logic [TBITS-1:0]         isif_data_dout;
  logic                     isif_last_dout;
  logic                     isif_empty_n;
  logic                     isif_read;
  logic                     qr_valid;
  logic [DATA_LENGTH*4-1:0] qr_in;
  logic                     qr_out_valid;
  logic [DATA_LENGTH*4-1:0] qr_out;
  logic [TBITS-1:0]         osif_data_din;
  logic [TBYTE-1:0]         osif_strb_din;
  logic                     osif_last_din;
  logic                     osif_user_din;
  logic                     osif_full_n;
  logic                     osif_write;
  logic                     busy;
  logic                     err_fmt;
  logic                     err_tmo;

  modport slave (
    input  isif_data_dout, isif_last_dout, isif_empty_n, qr_out_valid, qr_out, osif_full_n,
    output isif_read, qr_valid, qr_in, osif_data_din, osif_strb_din, osif_last_din,
           osif_user_din, osif_write, busy, err_fmt, err_tmo
  );

  modport master (
    output isif_data_dout, isif_last_dout, isif_empty_n, qr_out_valid, qr_out, osif_full_n,
    input  isif_read, qr_valid, qr_in, osif_data_din, osif_strb_din, osif_last_din,
           osif_user_din, osif_write, busy, err_fmt, err_tmo
  );
endinterface

// File: rtl/qr_job_sched.sv
// Job scheduler for a 4x4 QR datapath: gathers 8 input words into a matrix, issues its
// rows, collects 4 result rows (with timeout) and streams them out as 8 sign-extended words.
module qr_job_sched #(
  parameter int TBITS       = 32,
  parameter int TBYTE       = 4,
  parameter int DATA_LENGTH = 13,
  parameter int TIMEOUT     = 255
) (
  input  logic            clk,
  input  logic            rst,
  qr_job_sched_if.slave   bus
);
  localparam int DL = DATA_LENGTH;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_WB    = 3'd4
  } state_t;

  state_t              r_state;
  logic [2:0]          r_widx;
  logic [1:0]          r_iidx;
  logic [1:0]          r_ridx;
  logic [2:0]          r_oidx;
  logic [TW-1:0]       r_tmr;
  logic [DL-1:0]       r_mat [4][4];
  logic [DL-1:0]       r_res [4][4];
  logic                r_qr_valid;
  logic [4*DL-1:0]     r_qr_in;
  logic [TBITS-1:0]    r_osif_data;
  logic [TBYTE-1:0]    r_osif_strb;
  logic                r_osif_last;
  logic                r_osif_user;
  logic                r_busy;
  logic                r_err_fmt;
  logic                r_err_tmo;

  logic [DL-1:0]       w_elem_a;
  logic [DL-1:0]       w_elem_b;
  logic [4*DL-1:0]     w_row  [4];
  logic [TBITS-1:0]    w_word [8];
  logic                w_unused;

  function automatic logic [15:0] f_sext(input logic [DL-1:0] e);
    return {{(16-DL){e[DL-1]}}, e};
  endfunction

  // Bits above DATA_LENGTH in each 16-bit half are simply dropped.
  assign w_elem_a = bus.isif_data_dout[DL-1:0];
  assign w_elem_b = bus.isif_data_dout[16+DL-1:16];
  assign w_unused = ^bus.isif_data_dout;

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_row
    assign w_row[gi] = {r_mat[gi][3], r_mat[gi][2], r_mat[gi][1], r_mat[gi][0]};
  end
  for (gi = 0; gi < 8; gi++) begin : g_word
    assign w_word[gi] = TBITS'({f_sext(r_res[gi/2][2*(gi%2)+1]), f_sext(r_res[gi/2][2*(gi%2)])});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_widx      <= '0;
      r_iidx      <= '0;
      r_ridx      <= '0;
      r_oidx      <= '0;
      r_tmr       <= '0;
      r_qr_valid  <= 1'b0;
      r_qr_in     <= '0;
      r_osif_data <= '0;
      r_osif_strb <= '0;
      r_osif_last <= 1'b0;
      r_osif_user <= 1'b0;
      r_busy      <= 1'b0;
      r_err_fmt   <= 1'b0;
      r_err_tmo   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          r_mat[i][j] <= '0;
          r_res[i][j] <= '0;
        end
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.isif_empty_n) begin
            r_state <= S_READ;
            r_busy  <= 1'b1;
            r_widx  <= '0;
          end
        end
        S_READ: begin
          if (bus.isif_empty_n) begin
            r_mat[r_widx[2:1]][{r_widx[0], 1'b0}] <= w_elem_a;
            r_mat[r_widx[2:1]][{r_widx[0], 1'b1}] <= w_elem_b;
            r_widx <= r_widx + 3'd1;
            if (r_widx == 3'd7) begin
              if (!bus.isif_last_dout) r_err_fmt <= 1'b1;
              r_state    <= S_ISSUE;
              r_qr_valid <= 1'b1;
              r_qr_in    <= w_row[0];
              r_iidx     <= '0;
            end else if (bus.isif_last_dout) begin
              r_err_fmt <= 1'b1;
              r_state   <= S_IDLE;
              r_busy    <= 1'b0;
            end
          end
        end
        S_ISSUE: begin
          // qr_valid was raised on entry, so it covers exactly the four ISSUE cycles.
          if (r_iidx == 2'd3) begin
            r_qr_valid <= 1'b0;
            r_qr_in    <= '0;
            r_state    <= S_WAIT;
            r_tmr      <= '0;
            r_ridx     <= '0;
          end else begin
            r_iidx  <= r_iidx + 2'd1;
            r_qr_in <= w_row[r_iidx + 2'd1];
          end
        end
        S_WAIT: begin
          r_tmr <= r_tmr + TW'(1);
          if (bus.qr_out_valid && r_ridx == 2'd3) begin
            for (int c = 0; c < 4; c++) r_res[3][c] <= bus.qr_out[c*DL +: DL];
            r_state     <= S_WB;
            r_oidx      <= '0;
            r_osif_data <= w_word[0];
            r_osif_strb <= '1;
            r_osif_user <= 1'b1;
            r_osif_last <= 1'b0;
          end else if (r_tmr == TW'(TIMEOUT - 1)) begin
            r_err_tmo <= 1'b1;
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
          end else if (bus.qr_out_valid) begin
            for (int c = 0; c < 4; c++) r_res[r_ridx][c] <= bus.qr_out[c*DL +: DL];
            r_ridx <= r_ridx + 2'd1;
          end
        end
        S_WB: begin
          if (bus.osif_full_n) begin
            if (r_oidx == 3'd7) begin
              r_state     <= S_IDLE;
              r_busy      <= 1'b0;
              r_osif_data <= '0;
              r_osif_strb <= '0;
              r_osif_user <= 1'b0;
              r_osif_last <= 1'b0;
            end else begin
              r_oidx      <= r_oidx + 3'd1;
              r_osif_data <= w_word[r_oidx + 3'd1];
              r_osif_user <= 1'b0;
              r_osif_last <= (r_oidx == 3'd6);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.isif_read     = (r_state == S_READ) && bus.isif_empty_n;
  assign bus.osif_write    = (r_state == S_WB) && bus.osif_full_n;
  assign bus.qr_valid      = r_qr_valid;
  assign bus.qr_in         = r_qr_in;
  assign bus.osif_data_din = r_osif_data;
  assign bus.osif_strb_din = r_osif_strb;
  assign bus.osif_last_din = r_osif_last;
  assign bus.osif_user_din = r_osif_user;
  assign bus.busy          = r_busy;
  assign bus.err_fmt       = r_err_fmt;
  assign bus.err_tmo       = r_err_tmo;
endmodule

// File: tb/tb_qr_job_sched.sv
// Directed-plus-random bench for qr_job_sched with a behavioural datapath and output model.
module tb_qr_job_sched;
  localparam int TBITS = 32;
  localparam int TBYTE = 4;
  localparam int DL    = 13;
  localparam int TMO   = 20;
  localparam int DPLAT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  qr_job_sched_if #(.TBITS(TBITS), .TBYTE(TBYTE), .DATA_LENGTH(DL)) bus ();

  qr_job_sched #(.TBITS(TBITS), .TBYTE(TBYTE), .DATA_LENGTH(DL), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Datapath model: echoes each issued row, elementwise XOR dp_key, DPLAT cycles later.
  typedef struct { int due; logic [4*DL-1:0] row; } dp_t;
  dp_t             dp_q[$];
  logic [DL-1:0]   dp_key;
  bit              dp_mute;
  int              qv_cnt;
  logic [4*DL-1:0] exp_row [4];

  always @(negedge clk) begin
    if (bus.qr_valid) begin
      chk($sformatf("qr_in_row%0d", qv_cnt), 64'(bus.qr_in), 64'(exp_row[qv_cnt % 4]));
      qv_cnt++;
      if (!dp_mute) dp_q.push_back('{due: cyc + DPLAT, row: bus.qr_in ^ {4{dp_key}}});
    end
    if (dp_q.size() > 0 && dp_q[0].due <= cyc) begin
      bus.qr_out_valid = 1'b1;
      bus.qr_out       = dp_q[0].row;
      void'(dp_q.pop_front());
    end else begin
      bus.qr_out_valid = 1'b0;
      bus.qr_out       = 52'({$urandom, $urandom});
    end
  end

  // Output collector; a pending word that was not written must not change.
  logic [TBYTE+TBITS+1:0] out_q[$];
  logic [TBYTE+TBITS+1:0] hold_word;
  bit                     hold_v = 0;

  always @(negedge clk) begin
    if (hold_v)
      chk("hold_stable", 64'({bus.osif_strb_din, bus.osif_last_din, bus.osif_user_din, bus.osif_data_din}),
          64'(hold_word));
    if (bus.osif_write) begin
      out_q.push_back({bus.osif_strb_din, bus.osif_last_din, bus.osif_user_din, bus.osif_data_din});
      hold_v = 0;
    end else begin
      hold_v    = (bus.osif_strb_din != '0);
      hold_word = {bus.osif_strb_din, bus.osif_last_din, bus.osif_user_din, bus.osif_data_din};
    end
  end

  logic [31:0] jw [8];

  function automatic logic [15:0] ref_el(input logic [15:0] half, input logic [DL-1:0] key);
    logic signed [DL-1:0] e;
    int v;
    e = half[DL-1:0] ^ key;
    v = e;
    return v[15:0];
  endfunction

  function automatic logic [TBYTE+TBITS+1:0] exp_word(input int j);
    return {4'hF, (j == 7), (j == 0), ref_el(jw[j][31:16], dp_key), ref_el(jw[j][15:0], dp_key)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prep();
    for (int k = 0; k < 4; k++)
      exp_row[k] = {jw[2*k+1][16+DL-1:16], jw[2*k+1][DL-1:0], jw[2*k][16+DL-1:16], jw[2*k][DL-1:0]};
    qv_cnt = 0;
    out_q.delete();
  endtask

  task automatic feed(input int n, input int last_at, input bit gaps);
    int  k = 0;
    int  g = 0;
    bit  acc;
    while (k < n && g < 500) begin
      bus.isif_empty_n   = (g == 0) ? 1'b1 : (gaps ? ($urandom_range(0, 3) != 0) : 1'b1);
      bus.isif_data_dout = jw[k];
      bus.isif_last_dout = (k == last_at);
      #1;
      acc = bus.isif_read;
      if (g == 0) chk("idle_no_read", 64'(acc), 64'(0));
      tick();
      if (acc) k++;
      g++;
    end
    bus.isif_empty_n   = 1'b0;
    bus.isif_last_dout = 1'b0;
    chk("feed_done", 64'(k), 64'(n));
  endtask

  task automatic drain(input int fmode);
    int g  = 0;
    int ph = 0;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    while (g < 300) begin
      if (fmode == 1)
        bus.osif_full_n = ($urandom_range(0, 1) == 1);
      else if (fmode == 2 && bus.osif_strb_din != '0) begin
        bus.osif_full_n = pat[ph % 4];
        ph++;
      end else
        bus.osif_full_n = 1'b1;
      tick();
      g++;
      if (out_q.size() >= 8 && !bus.busy) break;
    end
    bus.osif_full_n = 1'b1;
  endtask

  task automatic run_job(input string name, input int last_at, input int fmode, input bit gaps,
                         input bit exp_fmt);
    bit abort = (last_at >= 0 && last_at < 7);
    prep();
    feed(abort ? last_at + 1 : 8, last_at, gaps);
    if (abort) repeat (8) tick();
    else drain(fmode);
    chk({name, "_qv_pulses"}, 64'(qv_cnt), abort ? 64'(0) : 64'(4));
    chk({name, "_n_words"}, 64'(out_q.size()), abort ? 64'(0) : 64'(8));
    for (int j = 0; j < out_q.size() && j < 8; j++)
      chk($sformatf("%s_word%0d", name, j), 64'(out_q[j]), 64'(exp_word(j)));
    chk({name, "_busy"}, 64'(bus.busy), 64'(0));
    chk({name, "_err_fmt"}, 64'(bus.err_fmt), 64'(exp_fmt));
    chk({name, "_err_tmo"}, 64'(bus.err_tmo), 64'(0));
    $display("[TB] job %s done: pulses=%0d words=%0d err_fmt=%0d", name, qv_cnt, out_q.size(), bus.err_fmt);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_errs", 64'({bus.err_fmt, bus.err_tmo, bus.busy, bus.qr_valid}), 64'(0));
    rst = 1'b0;
    dp_q.delete();
    tick();
  endtask

  task automatic rand_words();
    for (int k = 0; k < 8; k++) jw[k] = $urandom;
  endtask

  initial begin
    int g;
    rst                = 1'b1;
    bus.isif_empty_n   = 1'b1;
    bus.isif_data_dout = '0;
    bus.isif_last_dout = 1'b0;
    bus.osif_full_n    = 1'b1;
    dp_key             = '0;
    dp_mute            = 1'b0;
    repeat (3) tick();
    chk("rst_isif_read", 64'(bus.isif_read), 64'(0));
    chk("rst_ctrl", 64'({bus.qr_valid, bus.busy, bus.err_fmt, bus.err_tmo, bus.osif_write}), 64'(0));
    chk("rst_out", 64'({bus.osif_strb_din, bus.osif_last_din, bus.osif_user_din, bus.osif_data_din}), 64'(0));
    bus.isif_empty_n = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_out", 64'({bus.qr_valid, bus.busy, bus.osif_write, bus.isif_read}), 64'(0));
    tick();

    // Elements 1..16, pure echo.
    for (int k = 0; k < 8; k++) jw[k] = {16'(2*k+2), 16'(2*k+1)};
    run_job("seq", 7, 0, 0, 1'b0);

    rand_words();
    jw[0][15:0] = 16'h1FFF;
    run_job("neg", 7, 0, 0, 1'b0);
    if (out_q.size() > 0) chk("neg_word0_lo", 64'(out_q[0][15:0]), 64'(16'hFFFF));

    for (int r = 0; r < 6; r++) begin
      rand_words();
      dp_key = DL'($urandom);
      run_job($sformatf("rnd%0d", r), 7, 1, 1, 1'b0);
    end

    rand_words();
    run_job("fullpat", 7, 2, 0, 1'b0);

    // Missing last on word 7 flags but completes; flag is sticky across a clean job.
    rand_words();
    run_job("nolast", -1, 1, 1, 1'b1);
    rand_words();
    run_job("sticky", 7, 0, 0, 1'b1);
    do_reset();

    rand_words();
    run_job("early_last", 3, 0, 0, 1'b1);
    rand_words();
    run_job("after_fmt", 7, 0, 1, 1'b1);
    do_reset();

    // Datapath silent: timeout exactly TMO cycles after WAIT entry.
    rand_words();
    dp_mute = 1'b1;
    prep();
    feed(8, 7, 0);
    g = 0;
    while (bus.qr_valid && g < 50) begin
      tick();
      g++;
    end
    repeat (TMO - 1) tick();
    chk("tmo_early", 64'(bus.err_tmo), 64'(0));
    tick();
    chk("tmo_set", 64'(bus.err_tmo), 64'(1));
    chk("tmo_busy", 64'(bus.busy), 64'(0));
    repeat (4) tick();
    chk("tmo_no_write", 64'(out_q.size()), 64'(0));
    chk("tmo_pulses", 64'(qv_cnt), 64'(4));
    $display("[TB] job timeout done: err_tmo=%0d", bus.err_tmo);
    dp_mute = 1'b0;
    do_reset();

    // Reset while row 2 is on qr_in.
    rand_words();
    prep();
    feed(8, 7, 0);
    tick();
    tick();
    chk("mid_row2", 64'(bus.qr_in), 64'(exp_row[2]));
    rst = 1'b1;
    #1;
    chk("mid_rst_ctrl", 64'({bus.qr_valid, bus.busy}), 64'(0));
    tick();
    rst = 1'b0;
    dp_q.delete();
    out_q.delete();
    repeat (10) tick();
    chk("mid_no_write", 64'(out_q.size()), 64'(0));
    $display("[TB] job reset_mid done: busy=%0d", bus.busy);
    rand_words();
    dp_key = DL'($urandom);
    run_job("post_mid", 7, 1, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed time %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
